// File: rtl/fast_parallel_fir_prog_if.sv
// Stream and coefficient-load bundle for the programmable parallel FIR.
// slave = filter side, master = source/sink side.
interface fast_parallel_fir_prog_if #(
  parameter int INP_WIDTH  = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUTP_WIDTH = 16,
  parameter int L          = 3
);
  logic                         coef_start;
  logic                         coef_valid;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         coef_ready;
  logic                         coef_loaded;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [INP_WIDTH-1:0]  x [L];
  logic                         out_valid;
  logic signed [OUTP_WIDTH-1:0] y [L];
  logic                         sat_flag;

  modport slave (
    input  coef_start, coef_valid, coef_data,
    input  in_valid, x,
    output coef_ready, coef_loaded,
    output in_ready, out_valid, y, sat_flag
  );

  modport master (
    output coef_start, coef_valid, coef_data,
    output in_valid, x,
    input  coef_ready, coef_loaded,
    input  in_ready, out_valid, y, sat_flag
  );
endinterface

// File: rtl/fast_parallel_fir_prog.sv
// L-lane block FIR with serially loaded coefficients,
// 2-clk latency, round/saturate output stage.
module fast_parallel_fir_prog #(
  parameter int INP_WIDTH  = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUTP_WIDTH = 16,
  parameter int L          = 3,
  parameter int NTAPS      = 6,
  parameter int FRAC_SHIFT = 15
) (
  input logic clk,
  input logic rst_n,
  fast_parallel_fir_prog_if.slave bus
);
  localparam int HW = NTAPS - 1 + L;
  localparam int PW = INP_WIDTH + COEF_WIDTH;
  localparam int AW = PW + $clog2(NTAPS);
  localparam int IW = $clog2(NTAPS + 1);
  localparam int RS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [AW:0] RND =
    (FRAC_SHIFT > 0) ? ((AW+1)'(1) << RS) : '0;
  localparam logic signed [AW:0] MAXV =
    {{(AW+2-OUTP_WIDTH){1'b0}}, {(OUTP_WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] MINV =
    {{(AW+2-OUTP_WIDTH){1'b1}}, {(OUTP_WIDTH-1){1'b0}}};

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0]                r_idx;
  logic signed [COEF_WIDTH-1:0] r_h   [NTAPS];
  logic signed [INP_WIDTH-1:0]  r_win [HW];
  logic                         r_v0;
  logic                         r_v1;
  logic                         r_v2;
  logic signed [AW-1:0]         r_acc [L];
  logic signed [OUTP_WIDTH-1:0] r_y   [L];
  logic                         r_sat;

  logic                         w_coef_acc;
  logic                         w_in_acc;
  logic                         w_last;
  logic signed [PW-1:0]         w_prod;
  logic signed [AW-1:0]         w_acc [L];
  logic signed [AW:0]           w_sum [L];
  logic signed [AW:0]           w_rnd [L];
  logic signed [OUTP_WIDTH-1:0] w_y   [L];
  logic [L-1:0]                 w_clip;

  assign w_last     = (r_idx == IW'(NTAPS - 1));
  assign w_coef_acc = bus.coef_valid && (r_state == S_LOAD)
                      && !bus.coef_start;
  assign w_in_acc   = bus.in_valid && (r_state == S_RUN)
                      && !bus.coef_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      bus.coef_start:       w_state_nxt = S_LOAD;
      w_coef_acc && w_last: w_state_nxt = S_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      for (int j = 0; j < NTAPS; j++) r_h[j] <= '0;
    end else if (bus.coef_start) begin
      r_idx <= '0;
    end else if (w_coef_acc) begin
      r_h[r_idx] <= bus.coef_data;
      r_idx      <= w_last ? '0 : r_idx + IW'(1);
    end
  end

  // Window = NTAPS-1 past samples followed by the newest block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HW; i++) r_win[i] <= '0;
    end else if (bus.coef_start) begin
      for (int i = 0; i < HW; i++) r_win[i] <= '0;
    end else if (w_in_acc) begin
      for (int i = 0; i < HW - L; i++) r_win[i] <= r_win[i+L];
      for (int k = 0; k < L; k++) r_win[HW-L+k] <= bus.x[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v0 <= w_in_acc;
      r_v1 <= r_v0 && !bus.coef_start;
      r_v2 <= r_v1 && !bus.coef_start;
    end
  end

  always_comb begin
    w_prod = '0;
    for (int k = 0; k < L; k++) begin
      w_acc[k] = '0;
      for (int j = 0; j < NTAPS; j++) begin
        w_prod   = PW'(r_h[j]) * PW'(r_win[NTAPS-1+k-j]);
        w_acc[k] = w_acc[k] + AW'(w_prod);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) r_acc[k] <= '0;
    end else if (r_v0) begin
      for (int k = 0; k < L; k++) r_acc[k] <= w_acc[k];
    end
  end

  always_comb begin
    w_clip = '0;
    for (int k = 0; k < L; k++) begin
      w_sum[k] = (AW+1)'(r_acc[k]) + RND;
      w_rnd[k] = w_sum[k] >>> FRAC_SHIFT;
      w_y[k]   = w_rnd[k][OUTP_WIDTH-1:0];
      if (w_rnd[k] > MAXV) begin
        w_y[k]    = {1'b0, {(OUTP_WIDTH-1){1'b1}}};
        w_clip[k] = 1'b1;
      end else if (w_rnd[k] < MINV) begin
        w_y[k]    = {1'b1, {(OUTP_WIDTH-1){1'b0}}};
        w_clip[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) r_y[k] <= '0;
      r_sat <= 1'b0;
    end else if (r_v1 && !bus.coef_start) begin
      for (int k = 0; k < L; k++) r_y[k] <= w_y[k];
      r_sat <= |w_clip;
    end
  end

  assign bus.coef_ready  = (r_state == S_LOAD);
  assign bus.coef_loaded = (r_state == S_RUN);
  assign bus.in_ready    = (r_state == S_RUN);
  assign bus.out_valid   = r_v2;
  assign bus.sat_flag    = r_sat;
  assign bus.y           = r_y;
endmodule

// File: tb/tb_fast_parallel_fir_prog.sv
// Scoreboard bench for fast_parallel_fir_prog: model-driven
// expectations, latency-tagged queue, per-scenario tasks.
module tb_fast_parallel_fir_prog;
  localparam int L  = 3;
  localparam int NT = 6;
  localparam int FS = 15;

  typedef logic [L-1:0][15:0] blk_t;
  typedef logic [NT-1:0][15:0] coef_t;
  typedef struct {
    blk_t y;
    bit   sat;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fast_parallel_fir_prog_if #(
    .INP_WIDTH(16), .COEF_WIDTH(16), .OUTP_WIDTH(16), .L(L)
  ) bus ();

  fast_parallel_fir_prog #(
    .INP_WIDTH(16), .COEF_WIDTH(16), .OUTP_WIDTH(16),
    .L(L), .NTAPS(NT), .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int     n_pass = 0;
  int     n_chk  = 0;
  int     cyc    = 0;
  exp_t   q[$];
  longint mh [NT];
  longint ms [NT-1];
  blk_t   obs_m;
  exp_t   e_m;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < L; k++) obs_m[k] = bus.y[k];
      if (bus.out_valid) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_out got out_valid=1 y=%h want out_valid=0", obs_m);
        end else begin
          e_m = q.pop_front();
          if (e_m.due !== cyc || obs_m !== e_m.y || bus.sat_flag !== e_m.sat)
            $display("FAIL out_block got y=%h sat=%b cyc=%0d want y=%h sat=%b cyc=%0d",
                     obs_m, bus.sat_flag, cyc, e_m.y, e_m.sat, e_m.due);
          else n_pass++;
        end
      end else if (q.size() > 0 && q[0].due < cyc) begin
        n_chk++;
        $display("FAIL missing_out got out_valid=0 cyc=%0d want y=%h at cyc=%0d",
                 cyc, q[0].y, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  function automatic void model_clear_hist();
    for (int i = 0; i < NT-1; i++) ms[i] = 0;
  endfunction

  function automatic void model_step(input blk_t xb, output blk_t ey, output bit es);
    longint s [NT-1+L];
    longint acc;
    longint r;
    es = 1'b0;
    for (int i = 0; i < NT-1; i++) s[i] = ms[i];
    for (int k = 0; k < L; k++) s[NT-1+k] = longint'($signed(xb[k]));
    for (int k = 0; k < L; k++) begin
      acc = 0;
      for (int j = 0; j < NT; j++) acc += mh[j] * s[NT-1+k-j];
      r = (acc + (longint'(1) <<< (FS-1))) >>> FS;
      if (r > 32767) begin r = 32767; es = 1'b1; end
      else if (r < -32768) begin r = -32768; es = 1'b1; end
      ey[k] = 16'(r);
    end
    for (int i = 0; i < NT-1; i++) s[i] = s[i+L];
    for (int i = 0; i < NT-1; i++) ms[i] = s[i];
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.coef_start = 1'b0;
    bus.coef_valid = 1'b0;
    bus.in_valid   = 1'b0;
    for (int k = 0; k < L; k++) bus.x[k] = 16'($urandom());
  endtask

  task automatic send(input blk_t xb, input bit lit, input blk_t ly, input bit ls);
    blk_t ey;
    bit   es;
    @(negedge clk);
    bus.coef_start = 1'b0;
    bus.coef_valid = 1'b0;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < L; k++) bus.x[k] = xb[k];
    if (bus.in_ready) begin
      model_step(xb, ey, es);
      q.push_back('{y: lit ? ly : ey, sat: lit ? ls : es, due: cyc + 3});
    end
  endtask

  task automatic start();
    @(negedge clk);
    bus.coef_start = 1'b1;
    bus.coef_valid = 1'b1;
    bus.coef_data  = 16'h7777;
    bus.in_valid   = 1'b0;
    q.delete();
    model_clear_hist();
  endtask

  task automatic load(input coef_t hv, input int first, input int cnt);
    for (int j = first; j < first + cnt; j++) begin
      @(negedge clk);
      bus.coef_start = 1'b0;
      bus.coef_valid = 1'b1;
      bus.in_valid   = 1'b0;
      bus.coef_data  = hv[j];
      mh[j] = longint'($signed(hv[j]));
    end
    @(negedge clk);
    bus.coef_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if (bus.coef_ready !== 1'b1) $display("FAIL %s_coef_ready got %b want 1", tag, bus.coef_ready);
    else n_pass++;
    n_chk++;
    if (bus.coef_loaded !== 1'b0) $display("FAIL %s_coef_loaded got %b want 0", tag, bus.coef_loaded);
    else n_pass++;
    n_chk++;
    if (bus.in_ready !== 1'b0) $display("FAIL %s_in_ready got %b want 0", tag, bus.in_ready);
    else n_pass++;
    n_chk++;
    if (bus.out_valid !== 1'b0) $display("FAIL %s_out_valid got %b want 0", tag, bus.out_valid);
    else n_pass++;
    n_chk++;
    if (bus.y[0] !== 16'h0 || bus.y[1] !== 16'h0 || bus.y[2] !== 16'h0)
      $display("FAIL %s_y got %h %h %h want 0", tag, bus.y[0], bus.y[1], bus.y[2]);
    else n_pass++;
    n_chk++;
    if (bus.sat_flag !== 1'b0) $display("FAIL %s_sat got %b want 0", tag, bus.sat_flag);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    for (int k = 0; k < L; k++) bus.x[k] = 16'h1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle();
    for (int j = 0; j < NT; j++) mh[j] = 0;
    model_clear_hist();
  endtask

  task automatic test_load();
    for (int j = 0; j < NT; j++) begin
      @(negedge clk);
      n_chk++;
      if (bus.coef_loaded !== 1'b0) $display("FAIL load_partial_loaded got %b want 0 word %0d", bus.coef_loaded, j);
      else n_pass++;
      bus.coef_valid = 1'b1;
      bus.coef_data  = 16'((j + 1) * 16'h0800);
      mh[j] = longint'((j + 1) * 16'h0800);
    end
    @(negedge clk);
    bus.coef_valid = 1'b0;
    n_chk++;
    if (bus.coef_loaded !== 1'b1 || bus.in_ready !== 1'b1 || bus.coef_ready !== 1'b0)
      $display("FAIL load_done got loaded=%b in_ready=%b coef_ready=%b want 1 1 0",
               bus.coef_loaded, bus.in_ready, bus.coef_ready);
    else n_pass++;
  endtask

  task automatic impulse_seq(input bit stalls);
    blk_t xs [4];
    blk_t ys [4];
    xs[0] = '0; xs[0][0] = 16'h1000;
    xs[1] = '0; xs[2] = '0; xs[3] = '0;
    ys[0] = {16'h0300, 16'h0200, 16'h0100};
    ys[1] = {16'h0600, 16'h0500, 16'h0400};
    ys[2] = '0; ys[3] = '0;
    for (int b = 0; b < 4; b++) begin
      send(xs[b], 1'b1, ys[b], 1'b0);
      if (stalls) repeat ($urandom_range(1, 4)) idle();
    end
    idle();
    drain();
  endtask

  task automatic test_impulse();
    impulse_seq(1'b0);
  endtask

  task automatic test_stalls();
    impulse_seq(1'b1);
  endtask

  task automatic test_saturation();
    coef_t hv;
    blk_t  xp, xn, yp, yn;
    for (int j = 0; j < NT; j++) hv[j] = 16'h7FFF;
    xp = {L{16'h7FFF}}; yp = {L{16'h7FFF}};
    xn = {L{16'h8000}}; yn = {L{16'h8000}};
    start();
    load(hv, 0, NT);
    send(xp, 1'b0, '0, 1'b0);
    send(xp, 1'b0, '0, 1'b0);
    send(xp, 1'b1, yp, 1'b1);
    send(xp, 1'b1, yp, 1'b1);
    send(xn, 1'b0, '0, 1'b0);
    send(xn, 1'b0, '0, 1'b0);
    send(xn, 1'b1, yn, 1'b1);
    send(xn, 1'b1, yn, 1'b1);
    idle();
    drain();
  endtask

  task automatic test_random();
    coef_t hv;
    blk_t  xb;
    for (int j = 0; j < NT; j++) hv[j] = 16'($urandom());
    start();
    load(hv, 0, NT);
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < L; k++) xb[k] = 16'($urandom());
      send(xb, 1'b0, '0, 1'b0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
    end
    idle();
    drain();
  endtask

  task automatic test_reload();
    coef_t hv;
    blk_t  xb, ye;
    xb = {16'h0123, 16'h0456, 16'h0789};
    send(xb, 1'b0, '0, 1'b0);
    send(xb, 1'b0, '0, 1'b0);
    start();
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.coef_start = 1'b0;
    bus.coef_valid = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.coef_ready !== 1'b1)
      $display("FAIL reload_flush got out_valid=%b in_ready=%b coef_ready=%b want 0 0 1",
               bus.out_valid, bus.in_ready, bus.coef_ready);
    else n_pass++;
    hv = '0;
    hv[0] = 16'h4000; hv[1] = 16'h2000; hv[2] = 16'h1000;
    for (int j = 0; j < NT; j++) begin
      bus.coef_valid = 1'b1;
      bus.coef_data  = hv[j];
      mh[j] = longint'($signed(hv[j]));
      @(negedge clk);
      n_chk++;
      if (bus.in_ready !== (j == NT - 1) || bus.out_valid !== 1'b0)
        $display("FAIL reload_word%0d got in_ready=%b out_valid=%b want %b 0",
                 j, bus.in_ready, bus.out_valid, j == NT - 1);
      else n_pass++;
    end
    bus.coef_valid = 1'b0;
    bus.in_valid   = 1'b0;
    xb = '0; xb[0] = 16'h2000;
    ye = {16'h0400, 16'h0800, 16'h1000};
    send(xb, 1'b1, ye, 1'b0);
    xb = '0;
    ye = '0;
    send(xb, 1'b1, ye, 1'b0);
    send(xb, 1'b1, ye, 1'b0);
    idle();
    drain();
  endtask

  task automatic test_async_reset();
    coef_t hv;
    blk_t  xb;
    for (int j = 0; j < NT; j++) hv[j] = 16'(16'h0400 * (j + 2));
    start();
    load(hv, 0, 3);
    #2 rst_n = 1'b0;
    q.delete();
    for (int j = 0; j < NT; j++) mh[j] = 0;
    model_clear_hist();
    #1 check_reset_outputs("rst_mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    load(hv, 0, 3);
    n_chk++;
    if (bus.coef_loaded !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL rst_partial got loaded=%b in_ready=%b want 0 0", bus.coef_loaded, bus.in_ready);
    else n_pass++;
    load(hv, 3, 3);
    n_chk++;
    if (bus.coef_loaded !== 1'b1) $display("FAIL rst_full_load got %b want 1", bus.coef_loaded);
    else n_pass++;
    xb = {16'h0000, 16'h0000, 16'h4000};
    send(xb, 1'b0, '0, 1'b0);
    xb = {16'h1000, 16'h2000, 16'h3000};
    send(xb, 1'b0, '0, 1'b0);
    send(xb, 1'b0, '0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    for (int j = 0; j < NT; j++) mh[j] = 0;
    model_clear_hist();
    #1 check_reset_outputs("rst_mid_stream");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < NT; j++) hv[j] = 16'($urandom_range(0, 16'h3FFF));
    load(hv, 0, NT);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < L; k++) xb[k] = 16'($urandom());
      send(xb, 1'b0, '0, 1'b0);
    end
    idle();
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.coef_start = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.in_valid   = 1'b0;
    for (int k = 0; k < L; k++) bus.x[k] = '0;
    test_reset();
    test_load();
    test_impulse();
    test_stalls();
    test_saturation();
    test_random();
    test_reload();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
